mvau_weight_stream: RTL and testbench

// - Multi-PE weight memory with built-in address sequencer and AXI-Stream output for the MVAU.
// - Holds PE parallel lanes of SIMD*TW-bit weights per word, one word per cycle.
// - Replays the full weight set NUM_REPS times per start (one pass per output pixel).
// - Optional runtime weight load port, so weights change without re-synthesis.

---
 rtl/mvau_wstream_pkg.sv | 15 +
 rtl/mvau_wstream_skid.sv | 54 +++++
 rtl/mvau_weight_stream.sv | 117 +++++++++++
 tb/tb_mvau_weight_stream.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mvau_wstream_pkg.sv
// Shared types and width helpers for the MVAU weight streamer.
package mvau_wstream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int word_w(input int pe, input int simd, input int tw);
    return pe * simd * tw;
  endfunction

  // Rep counter holds 0..NUM_REPS-1; sized with headroom so NUM_REPS=1 still gets 1 bit.
  function automatic int rep_w(input int num_reps);
    return $clog2(num_reps + 1);
  endfunction

endpackage

// File: rtl/mvau_wstream_skid.sv
// Two-entry registered skid buffer; output is a register, 1 cycle in to out.
// Backpressure: holds up to 2 words; 'space' also counts the word arriving this cycle.
module mvau_wstream_skid #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy,
  output logic         space
);

  logic [1:0]   cnt;
  logic [W-1:0] ent1;
  logic         pop;

  assign out_vld = (cnt != 2'd0);
  assign pop     = out_vld && out_rdy;
  // A read issued now lands one cycle later, so occupancy after this edge must leave a slot.
  assign space   = ({1'b0, cnt} + {2'b00, in_vld} - {2'b00, pop}) <= 3'd1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt     <= 2'd0;
      out_dat <= '0;
      ent1    <= '0;
    end else begin
      case ({in_vld, pop})
        2'b10: begin
          if (cnt == 2'd0) out_dat <= in_dat;
          else             ent1    <= in_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          out_dat <= ent1;
          cnt     <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            out_dat <= ent1;
            ent1    <= in_dat;
          end else begin
            out_dat <= in_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mvau_weight_stream.sv
// Weight RAM + address sequencer replaying WMEM_DEPTH words NUM_REPS times onto AXI-Stream.
// First tvalid 2 cycles after start; a read is issued only when the skid buffer can absorb it.
module mvau_weight_stream
  import mvau_wstream_pkg::*;
#(
  parameter int PE            = 2,
  parameter int SIMD          = 2,
  parameter int TW            = 1,
  parameter int WMEM_DEPTH    = 4,
  parameter int WMEM_ADDR_BW  = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1,
  parameter int NUM_REPS      = 4,
  parameter int RUNTIME_WRITE = 1,
  parameter     INIT_FILE     = ""
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [PE*SIMD*TW-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  input  logic                    wr_en,
  input  logic [WMEM_ADDR_BW-1:0] wr_addr,
  input  logic [PE*SIMD*TW-1:0]   wr_data,
  output logic                    wr_err
);

  localparam int WORD_W = word_w(PE, SIMD, TW);
  localparam int REP_W  = rep_w(NUM_REPS);
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
  localparam logic [REP_W-1:0]        LAST_REP  = REP_W'(NUM_REPS - 1);

  (* ram_style = "auto" *) logic [WORD_W-1:0] mem [WMEM_DEPTH];

  state_t                  state;
  logic [WMEM_ADDR_BW-1:0] rd_addr;
  logic [REP_W-1:0]        rep;
  logic [WORD_W-1:0]       rd_data;
  logic                    rd_vld;
  logic                    rd_last;
  logic                    space;
  logic                    issue;
  logic                    beat;
  logic                    wr_ok;

  assign issue = (state == RUN) && space;
  assign beat  = m_axis_tvalid && m_axis_tready;
  // Writes only while idle, which also rules out read/write collisions on the RAM.
  assign wr_ok = (RUNTIME_WRITE != 0) && wr_en && !busy && (int'(wr_addr) < WMEM_DEPTH);

  always_ff @(posedge aclk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (issue) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      rd_addr <= '0;
      rep     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      done    <= 1'b0;
      wr_err  <= (RUNTIME_WRITE != 0) && wr_en && busy;
      rd_vld  <= issue;
      rd_last <= issue && (rd_addr == LAST_ADDR) && (rep == LAST_REP);
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            rd_addr <= '0;
            rep     <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            if (rd_addr == LAST_ADDR) begin
              rd_addr <= '0;
              if (rep == LAST_REP) state <= DRAIN;
              else                 rep   <= rep + 1'b1;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (beat && m_axis_tlast) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mvau_wstream_skid #(.W(WORD_W + 1)) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in_vld  (rd_vld),
    .in_dat  ({rd_last, rd_data}),
    .out_vld (m_axis_tvalid),
    .out_dat ({m_axis_tlast, m_axis_tdata}),
    .out_rdy (m_axis_tready),
    .space   (space)
  );

endmodule

// File: tb/tb_mvau_weight_stream.sv
// Scoreboard bench for mvau_weight_stream: 4-word x 3-rep stream, 16-bit words.
module tb_mvau_weight_stream;

  localparam int PE = 2, SIMD = 2, TW = 4, DEPTH = 4, REPS = 3, AW = 2;
  localparam int WW = PE * SIMD * TW;
  localparam int BEATS = DEPTH * REPS;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start;
  logic          busy, done, wr_err;
  logic [WW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;

  mvau_weight_stream #(
    .PE(PE), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(AW),
    .NUM_REPS(REPS), .RUNTIME_WRITE(1), .INIT_FILE("")
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_pct = 100;

  logic [WW-1:0] model_mem [DEPTH];
  logic [WW:0]   sb [$];

  int beats, done_cnt, first_cyc, last_cyc;
  logic        stall_prev = 1'b0;
  logic [WW:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1 m_axis_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // Output monitor: scoreboard pops, stall stability, done counting.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (stall_prev) begin
        chk("stall_vld", {31'd0, m_axis_tvalid}, 32'd1);
        chk("stall_dat", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, held});
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        if (first_cyc < 0) first_cyc = cyc;
        if (m_axis_tlast) last_cyc = cyc;
        if (sb.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else chk("beat", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, sb.pop_front()});
      end
      if (done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [WW-1:0] d);
    @(posedge aclk);
    #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge aclk);
    #1;
    wr_en = 1'b0;
    chk("wr_err_idle", {31'd0, wr_err}, 32'd0);
    model_mem[a] = d;
  endtask

  // Push the expected stream, pulse start, check tvalid arrives exactly 2 cycles later.
  task automatic kick();
    for (int r = 0; r < REPS; r++)
      for (int a = 0; a < DEPTH; a++)
        sb.push_back({(a == DEPTH - 1) && (r == REPS - 1), model_mem[a]});
    beats = 0; done_cnt = 0; first_cyc = -1; last_cyc = -1;
    @(posedge aclk);
    #1 start = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;
    @(posedge aclk);
    #1 chk("tvalid_early", {31'd0, m_axis_tvalid}, 32'd0);
    @(posedge aclk);
    #1 chk("tvalid_lat2", {31'd0, m_axis_tvalid}, 32'd1);
  endtask

  task automatic wait_done(input logic check_contig);
    int done_seen = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge aclk);
      if (done) begin
        done_seen = cyc;
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        break;
      end
    end
    if (done_seen < 0) chk("done_timeout", 32'd0, 32'd1);
    else chk("done_after_last", done_seen - last_cyc, 32'd1);
    repeat (6) @(negedge aclk);
    chk("beat_count", beats, BEATS);
    chk("done_count", done_cnt, 32'd1);
    chk("sb_left", sb.size(), 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    if (check_contig) chk("contiguous", last_cyc - first_cyc, BEATS - 1);
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_wr_err", {31'd0, wr_err}, 32'd0);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tlast",  {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_tdata",  {16'd0, m_axis_tdata}, 32'd0);
    aresetn = 1'b1;

    wr(2'd0, 16'h1111); wr(2'd1, 16'h2222); wr(2'd2, 16'h3333); wr(2'd3, 16'h4444);

    ready_pct = 100;
    kick(); wait_done(1'b1);

    ready_pct = 50;
    kick(); wait_done(1'b0);

    // Write during a run must be rejected with a one-cycle wr_err pulse.
    ready_pct = 100;
    kick();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'hdead;
    @(posedge aclk);
    #1 wr_en = 1'b0;
    chk("wr_err_pulse", {31'd0, wr_err}, 32'd1);
    @(posedge aclk);
    #1 chk("wr_err_clear", {31'd0, wr_err}, 32'd0);
    wait_done(1'b1);
    kick(); wait_done(1'b1);

    // Reset partway through, then a full clean run from address 0.
    ready_pct = 50;
    kick();
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (beats >= 5) break;
    end
    chk("midrun_beats", {31'd0, beats >= 5}, 32'd1);
    @(posedge aclk);
    #1 aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("midrst_busy",   {31'd0, busy}, 32'd0);
    sb.delete();
    @(posedge aclk);
    #1 aresetn = 1'b1;
    ready_pct = 100;
    kick(); wait_done(1'b1);

    // start while running is ignored.
    kick();
    start = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;
    wait_done(1'b1);

    // Fresh random weights, random backpressure.
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), WW'($urandom));
    ready_pct = 70;
    kick(); wait_done(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
